// File: rtl/dekatron_step_sequencer_if.sv
// Request/status bundle between the owning counter logic and the dekatron step sequencer.
interface dekatron_step_sequencer_if;
  logic       i_request;
  logic       i_dec;
  logic       i_set;
  logic [3:0] i_in;
  logic       o_en;
  logic       o_dec_out;
  logic       o_busy;
  logic       o_ready;
  logic       o_carry;
  logic       o_err;
  logic [3:0] o_out;

  modport master (
    output i_request, i_dec, i_set, i_in,
    input  o_en, o_dec_out, o_busy, o_ready, o_carry, o_err, o_out
  );

  modport slave (
    input  i_request, i_dec, i_set, i_in,
    output o_en, o_dec_out, o_busy, o_ready, o_carry, o_err, o_out
  );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Drives the dekatron pulse sender one step at a time and tracks the glow digit.
//   state | meaning
//   IDLE  | waiting for a request, sender idle
//   PULSE | En held high for STEP_CYCLES cycles, DecOut = latched direction
//   CHECK | one cycle: move glow digit, decide whether more steps remain
//   DONE  | one-cycle Ready strobe with Carry/Err
module dekatron_step_sequencer #(
  parameter int COUNT       = 10,
  parameter int STEP_CYCLES = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  dekatron_step_sequencer_if.slave    bus
);

  localparam int              TW         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [4:0]      COUNT_W    = 5'(COUNT);
  localparam logic [4:0]      HALF_W     = 5'(COUNT / 2);
  localparam logic [3:0]      LAST       = 4'(COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]    r_out;
  logic [4:0]    r_rem;
  logic [TW-1:0] r_timer;
  logic          r_dir;
  logic          r_set_mode;
  logic          r_carry;
  logic          r_err;

  logic [4:0] w_in_ext;
  logic [4:0] w_out_ext;
  logic [4:0] w_diff;
  logic       w_req_err;
  logic       w_req_move;
  logic       w_req_dir;
  logic [4:0] w_req_rem;
  logic [3:0] w_out_step;
  logic       w_wrap;
  logic       w_en;
  logic       w_busy;
  logic       w_ready;

  // Request decode: forward distance modulo COUNT, then pick the shorter way round.
  always_comb begin
    w_in_ext   = {1'b0, bus.i_in};
    w_out_ext  = {1'b0, r_out};
    w_diff     = (w_in_ext >= w_out_ext) ? (w_in_ext - w_out_ext)
                                         : (w_in_ext + COUNT_W - w_out_ext);
    w_req_err  = bus.i_set && (w_in_ext >= COUNT_W);
    w_req_move = !bus.i_set || (!w_req_err && (w_diff != 5'd0));
    w_req_dir  = 1'b0;
    w_req_rem  = 5'd1;
    if (!bus.i_set) begin
      w_req_dir = bus.i_dec;
      w_req_rem = 5'd1;
    end else if (w_diff <= HALF_W) begin
      w_req_dir = 1'b0;
      w_req_rem = w_diff;
    end else begin
      w_req_dir = 1'b1;
      w_req_rem = COUNT_W - w_diff;
    end
  end

  always_comb begin
    w_out_step = 4'd0;
    w_wrap     = 1'b0;
    if (r_dir) begin
      w_wrap     = (r_out == 4'd0);
      w_out_step = w_wrap ? LAST : (r_out - 4'd1);
    end else begin
      w_wrap     = (r_out == LAST);
      w_out_step = w_wrap ? 4'd0 : (r_out + 4'd1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_en        = 1'b0;
    w_busy      = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_request) begin
          w_state_nxt = w_req_move ? ST_PULSE : ST_DONE;
        end
      end
      ST_PULSE: begin
        w_en   = 1'b1;
        w_busy = 1'b1;
        if (r_timer == '0) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_busy      = 1'b1;
        w_state_nxt = (r_rem == 5'd1) ? ST_DONE : ST_PULSE;
      end
      ST_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out      <= 4'd0;
      r_rem      <= 5'd0;
      r_timer    <= '0;
      r_dir      <= 1'b0;
      r_set_mode <= 1'b0;
      r_carry    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_request) begin
            r_err      <= w_req_err;
            r_carry    <= 1'b0;
            r_set_mode <= bus.i_set;
            r_dir      <= w_req_dir;
            r_rem      <= w_req_rem;
            r_timer    <= TIMER_LOAD;
          end
        end
        ST_PULSE: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_CHECK: begin
          r_out   <= w_out_step;
          r_rem   <= r_rem - 5'd1;
          r_timer <= TIMER_LOAD;
          // Carry only reports single-step wraps; Set moves report nothing.
          if (!r_set_mode) begin
            r_carry <= w_wrap;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_en      = w_en;
  assign bus.o_dec_out = w_en & r_dir;
  assign bus.o_busy    = w_busy;
  assign bus.o_ready   = w_ready;
  assign bus.o_carry   = w_ready & r_carry;
  assign bus.o_err     = w_ready & r_err;
  assign bus.o_out     = r_out;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed plus randomized checks of the step sequencer against a digit-level model.
module tb_dekatron_step_sequencer;
  localparam int S = 10;
  localparam int C = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   m_out    = 0;

  always #5 clk = ~clk;

  dekatron_step_sequencer_if bus ();

  dekatron_step_sequencer #(.COUNT(C), .STEP_CYCLES(S)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; expectations come from the digit arithmetic, not the RTL structure.
  task automatic do_op(input bit set, input bit dec, input logic [3:0] din, input bit inject);
    int n, d, lat, k, exp_dir, exp_final, exp_carry, exp_err;
    int en_bad, dec_bad, busy_bad;
    bit got, exp_en;
    exp_err = 0; exp_carry = 0; exp_dir = 0; n = 0; exp_final = m_out;
    if (set) begin
      if (int'(din) >= C) begin
        exp_err = 1;
      end else begin
        d = (int'(din) - m_out + C) % C;
        exp_final = int'(din);
        if (d == 0)          n = 0;
        else if (d <= C / 2) begin n = d;     exp_dir = 0; end
        else                 begin n = C - d; exp_dir = 1; end
      end
    end else begin
      n = 1;
      exp_dir   = dec;
      exp_final = dec ? (m_out + C - 1) % C : (m_out + 1) % C;
      exp_carry = dec ? (m_out == 0) : (m_out == C - 1);
    end
    lat = n * (S + 1) + 1;

    bus.i_request = 1'b1; bus.i_set = set; bus.i_dec = dec; bus.i_in = din;
    tick();
    bus.i_request = 1'b0;
    bus.i_set = 1'($urandom); bus.i_dec = 1'($urandom); bus.i_in = 4'($urandom);
    k = 1; got = 0; en_bad = 0; dec_bad = 0; busy_bad = 0;
    while (k <= lat + 5) begin
      exp_en = (k <= n * (S + 1)) && (((k - 1) % (S + 1)) < S);
      if (bus.o_en !== exp_en) en_bad++;
      if (bus.o_en === 1'b1 && bus.o_dec_out !== 1'(exp_dir)) dec_bad++;
      if (bus.o_ready === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.o_busy !== 1'b1) busy_bad++;
      if (inject && k == 3) begin
        bus.i_request = 1'b1; bus.i_set = 1'($urandom); bus.i_in = 4'($urandom);
      end
      if (k == 4) bus.i_request = 1'b0;
      tick();
      k++;
    end
    bus.i_request = 1'b0;
    check("ready_latency", got ? k : -1, lat);
    check("en_window", en_bad, 0);
    check("dec_out_stable", dec_bad, 0);
    check("busy_during_op", busy_bad, 0);
    check("out_at_ready", bus.o_out, exp_final);
    check("carry", bus.o_carry, exp_carry);
    check("err", bus.o_err, exp_err);
    check("busy_at_ready", bus.o_busy, 0);
    m_out = exp_final;
    tick();
    check("idle_ready", bus.o_ready, 0);
    check("idle_en", bus.o_en, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dsel;
    logic [3:0] tgt;
    bus.i_request = 1'b0; bus.i_set = 1'b0; bus.i_dec = 1'b0; bus.i_in = 4'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out", bus.o_out, 0);
    check("rst_en", bus.o_en, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_ready", bus.o_ready, 0);
    check("rst_carry", bus.o_carry, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_dec_out", bus.o_dec_out, 0);
    m_out = 0;

    do_op(0, 0, 4'd0, 0);   // 0 -> 1
    do_op(1, 0, 4'd0, 0);   // back to 0
    do_op(0, 1, 4'd0, 0);   // 0 -> 9, borrow
    do_op(0, 0, 4'd0, 0);   // 9 -> 0, carry
    do_op(1, 0, 4'd2, 0);
    do_op(1, 0, 4'd7, 0);   // forward 5
    do_op(1, 0, 4'd2, 0);   // forward 5 through wrap, no carry
    do_op(1, 0, 4'd8, 0);   // backward 4
    do_op(1, 0, 4'd12, 0);  // invalid digit
    do_op(1, 0, 4'd15, 0);
    do_op(1, 0, 4'd8, 0);   // already there
    do_op(1, 0, 4'd3, 1);   // ignored request while busy
    do_op(0, 1, 4'd0, 1);

    for (int i = 0; i < 24; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    end

    // Reset during the 4th PULSE cycle of a 3-step Set.
    tgt = 4'((m_out + 3) % C);
    bus.i_request = 1'b1; bus.i_set = 1'b1; bus.i_dec = 1'b0; bus.i_in = tgt;
    tick();
    bus.i_request = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    check("pre_rst_en", bus.o_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_en", bus.o_en, 0);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_out", bus.o_out, 0);
    check("midrst_ready", bus.o_ready, 0);
    m_out = 0;
    dsel = $urandom_range(0, 1);
    do_op(0, 1'(dsel), 4'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
